// File: rtl/pill_feeder_sim.sv
// pill_feeder_sim: behavioural model of a pill hopper feeding bottles that
// are advanced under the chute by a conveyor. Every register updates on
// clk_1khz and uses a synchronous active-low reset.
// Optional feature macro: PILL_STOCK_EN. When defined, finite hopper stock
// and refills are modelled. When undefined, stock is infinite and
// hopper_add is ignored.
module pill_feeder_sim #(
    parameter int PILL_PERIOD = 250,
    parameter int TRAVEL_TIME = 2000,
    parameter int STOCK_INIT  = 500,
    parameter int REFILL_AMT  = 100,
    parameter int STOCK_MAX   = 999
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       feed_en,
    input  logic       bottle_req,
    input  logic       hopper_add,
    input  logic       hopper_stop,
    input  logic       conveyor_stop,
    output logic       pill_pulse,
    output logic       bottle_ready,
    output logic [1:0] conv_state,
    output logic       hopper_empty,
    output logic [9:0] stock
);

    localparam int CNT_W    = (PILL_PERIOD > 1) ? $clog2(PILL_PERIOD) : 1;
    localparam int TRAVEL_W = (TRAVEL_TIME > 1) ? $clog2(TRAVEL_TIME) : 1;

    localparam logic [1:0] CONV_READY  = 2'd0;
    localparam logic [1:0] CONV_MOVING = 2'd1;
    localparam logic [1:0] CONV_JAMMED = 2'd2;

    logic [CNT_W-1:0]    pill_cnt;
    logic [TRAVEL_W-1:0] travel_cnt;
    logic                bottle_req_q;
    logic                feed_ok;
    logic                pill_due;
    logic                bottle_edge;

    // A bottle sits under the chute only while the conveyor is idle.
    assign bottle_ready = (conv_state == CONV_READY);
    assign feed_ok      = feed_en & ~hopper_stop & bottle_ready & ~hopper_empty;
    assign pill_due     = feed_ok & (pill_cnt == CNT_W'(PILL_PERIOD - 1));
    assign bottle_edge  = bottle_req & ~bottle_req_q;

    // Pill period counter and the one-cycle pill pulse.
    always_ff @(posedge clk_1khz) begin
        // NOTE: state is assigned with <= so every register samples the
        // pre-edge values of its neighbours regardless of statement order.
        if (!rst_n) begin
            pill_cnt   <= '0;
            pill_pulse <= 1'b0;
        end else begin
            pill_pulse <= pill_due;
            if (!feed_en) begin
                pill_cnt <= '0;
            end else if (pill_due) begin
                pill_cnt <= '0;
            end else if (feed_ok) begin
                pill_cnt <= pill_cnt + 1'b1;
            end
        end
    end

    // Conveyor state machine; the request edge register resets high so a
    // level already present at reset release is not seen as a new request.
    always_ff @(posedge clk_1khz) begin
        if (!rst_n) begin
            conv_state   <= CONV_READY;
            travel_cnt   <= '0;
            bottle_req_q <= 1'b1;
        end else begin
            bottle_req_q <= bottle_req;
            case (conv_state)
                CONV_READY: begin
                    if (bottle_edge) begin
                        conv_state <= CONV_MOVING;
                        travel_cnt <= TRAVEL_W'(TRAVEL_TIME - 1);
                    end
                end
                CONV_MOVING: begin
                    if (travel_cnt == '0) begin
                        conv_state <= conveyor_stop ? CONV_JAMMED : CONV_READY;
                    end else begin
                        travel_cnt <= travel_cnt - 1'b1;
                    end
                end
                CONV_JAMMED: begin
                    if (!conveyor_stop) begin
                        conv_state <= CONV_READY;
                    end
                end
                default: conv_state <= CONV_READY;
            endcase
        end
    end

`ifdef PILL_STOCK_EN
    logic        hopper_add_q;
    logic        refill_edge;
    logic [10:0] stock_sum;
    logic [10:0] stock_next;

    assign refill_edge = hopper_add & ~hopper_add_q;

    // Next stock: refill and pill draw combine before saturation.
    always_comb begin
        // NOTE: every always_comb output gets a value on entry, so no path
        // leaves it unassigned and no latch can be inferred.
        stock_sum = {1'b0, stock};
        if (refill_edge) begin
            stock_sum = stock_sum + 11'(REFILL_AMT);
        end
        if (pill_due) begin
            stock_sum = stock_sum - 11'd1;
        end
        stock_next = (stock_sum > 11'(STOCK_MAX)) ? 11'(STOCK_MAX) : stock_sum;
    end

    // Stock register with empty flag updated in the same cycle.
    always_ff @(posedge clk_1khz) begin
        if (!rst_n) begin
            stock        <= 10'(STOCK_INIT);
            hopper_empty <= (STOCK_INIT == 0);
            hopper_add_q <= 1'b1;
        end else begin
            stock        <= stock_next[9:0];
            hopper_empty <= (stock_next == 11'd0);
            hopper_add_q <= hopper_add;
        end
    end
`else
    // Infinite stock: constant outputs, refill input has no effect.
    assign stock        = 10'(STOCK_MAX);
    assign hopper_empty = 1'b0;

    logic unused_stock_cfg;
    assign unused_stock_cfg = hopper_add ^ (STOCK_INIT != 0) ^ (REFILL_AMT != 0);
`endif

endmodule
